// File: rtl/noc_packet_sink_pkg.sv
// Shared constants and packet/state types for the NoC receive endpoint.
package noc_pkg;
   localparam int NUM_NODES = 8;
   localparam int PKT_W = 12;
   localparam logic [3:0] TAG_BASE = 4'b0100;
   localparam logic [3:0] TAG_LAST = 4'b1011;

   typedef struct packed {
      logic [4:0] pad;
      logic [3:0] tag;
      logic [2:0] dest;
   } noc_pkt_t;

   typedef enum logic [1:0] {IDLE, DECODE, HOLD} sink_state_t;
endpackage

// File: rtl/noc_packet_sink_if.sv
// Two-phase bundled-data link from the async fabric into a clocked node.
interface noc_packet_sink_if #(parameter int WIDTH = 12);
   logic             l1_req;
   logic [WIDTH-1:0] l1_data;
   logic             l1_ack;

   modport master (output l1_req, output l1_data, input l1_ack);
   modport slave  (input l1_req, input l1_data, output l1_ack);
endinterface

// File: rtl/noc_packet_sink_sync_2ff.sv
// Two-flop synchroniser with async reset for the incoming two-phase request.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [1:0] ff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ff <= 2'b00;
      else       ff <= {ff[0], d};
   end

   assign q = ff[1];
endmodule

// File: rtl/noc_packet_sink.sv
// NoC receive endpoint: two-phase handshake, packet decode, per-source
// saturating counters and a sticky completion flag once every source hits LIMIT.
//
// state  | meaning
// IDLE   | waiting for req_s != ack, then latch bundled data
// DECODE | classify latched packet, bump one counter, pulse pkt_valid
// HOLD   | wait BL cycles, then toggle ack
module noc_packet_sink
   import noc_pkg::*;
#(
   parameter int         WIDTH      = 12,
   parameter logic [2:0] NODE_ID    = 3'b000,
   parameter int         CHECK_DEST = 1,
   parameter int         BL         = 0,
   parameter int         LIMIT      = 10000
) (
   input  logic                clk,
   input  logic                reset,
   noc_packet_sink_if.slave    l1,
   output logic                pkt_valid,
   output logic [2:0]          pkt_src,
   output logic                pkt_err,
   input  logic [2:0]          cnt_sel,
   output logic [31:0]         rx_count,
   output logic [15:0]         bad_count,
   output logic [15:0]         misroute_count,
   output logic                done
);
   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_DECODE = 2'(DECODE);
   localparam logic [1:0] ST_HOLD   = 2'(HOLD);
   localparam int HOLD_W = (BL > 0) ? $clog2(BL + 1) : 1;
   localparam logic [HOLD_W-1:0] BL_L = HOLD_W'(BL);

   logic [1:0]        state;
   logic              req_s;
   logic              ack_r;
   logic              pending;
   logic [WIDTH-1:0]  pkt_r;
   noc_pkt_t          pkt;
   logic              well_formed;
   logic              misroute;
   logic [2:0]        src;
   logic [HOLD_W-1:0] hold_cnt;
   logic [31:0]       rx_cnt [NUM_NODES];
   logic              all_done;

   sync_2ff u_sync (.clk(clk), .reset(reset), .d(l1.l1_req), .q(req_s));

   assign pending   = req_s ^ ack_r;
   assign l1.l1_ack = ack_r;

   assign pkt         = noc_pkt_t'(pkt_r[PKT_W-1:0]);
   assign well_formed = (pkt.pad == 5'd0) && (pkt.tag >= TAG_BASE) && (pkt.tag <= TAG_LAST);
   assign misroute    = (CHECK_DEST != 0) && (pkt.dest != NODE_ID);
   // Low three bits suffice: the well-formed tag range spans exactly eight values.
   assign src         = pkt.tag[2:0] - TAG_BASE[2:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         ack_r     <= 1'b0;
         pkt_r     <= '0;
         hold_cnt  <= '0;
         pkt_valid <= 1'b0;
         pkt_src   <= 3'd0;
         pkt_err   <= 1'b0;
      end else begin
         pkt_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  pkt_r <= l1.l1_data;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               pkt_valid <= 1'b1;
               pkt_src   <= src;
               pkt_err   <= !well_formed || misroute;
               hold_cnt  <= BL_L;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (hold_cnt == '0) begin
                  ack_r <= ~ack_r;
                  state <= ST_IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_NODES; i++) rx_cnt[i] <= '0;
         bad_count      <= '0;
         misroute_count <= '0;
      end else if (state == ST_DECODE) begin
         if (!well_formed) begin
            if (bad_count != '1) bad_count <= bad_count + 1'b1;
         end else begin
            if (rx_cnt[src] != '1) rx_cnt[src] <= rx_cnt[src] + 1'b1;
            if (misroute && misroute_count != '1) misroute_count <= misroute_count + 1'b1;
         end
      end
   end

   always_comb begin
      all_done = 1'b1;
      for (int i = 0; i < NUM_NODES; i++)
         if (rx_cnt[i] < 32'(LIMIT)) all_done = 1'b0;
   end

   // Sticky: stays set until reset even if LIMIT semantics change later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) done <= 1'b0;
      else       done <= done | all_done;
   end

   assign rx_count = rx_cnt[cnt_sel];
endmodule
